// File: rtl/register_pkg.sv
// Shared constants and lane helpers for the byte-enabled storage register.
// Optional even-parity storage is compiled in by defining REGISTER_PARITY_EN.
package register_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32'd32;
   localparam int unsigned DEFAULT_LANES = DEFAULT_WIDTH / 32'd8;
   localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VALUE = 32'h0000_0000;

   typedef enum logic [1:0] {
      LANE_HOLD  = 2'd0,
      LANE_LOAD  = 2'd1,
      LANE_CLEAR = 2'd2
   } lane_op_e;

   function automatic int unsigned lane_count(input int unsigned width);
      return width / 32'd8;
   endfunction

   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/register_lane.sv
// One 8-bit storage lane: enable, synchronous clear, async reset, optional parity bit.
// Parity storage and checking exist only when REGISTER_PARITY_EN is defined.
module register_lane
   import register_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       load,
   input  logic       clr,
   input  logic [7:0] d,
   input  logic [7:0] rst_val,
   output logic [7:0] q_next,
`ifdef REGISTER_PARITY_EN
   output logic       parity_err,
`endif
   output logic [7:0] q
);

   lane_op_e   op_s;
   logic [7:0] q_next_s;
   logic [7:0] q_r;

   // Select the lane operation; clear outranks load.
   always_comb begin
      op_s = LANE_HOLD;
      if (clr) begin
         op_s = LANE_CLEAR;
      end else if (load) begin
         op_s = LANE_LOAD;
      end else begin
         op_s = LANE_HOLD;
      end
   end

   // Next stored byte; hold path never looks at d, so X on d cannot leak in.
   always_comb begin
      q_next_s = q_r;
      case (op_s)
         LANE_HOLD:  q_next_s = q_r;
         LANE_LOAD:  q_next_s = d;
         LANE_CLEAR: q_next_s = rst_val;
         default:    q_next_s = q_r;
      endcase
   end

   // Storage flops.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q_r <= rst_val;
      end else begin
         q_r <= q_next_s;
      end
   end

   assign q      = q_r;
   assign q_next = q_next_s;

`ifdef REGISTER_PARITY_EN
   logic parity_r;

   // Stored parity follows every change of the data byte.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         parity_r <= even_parity(rst_val);
      end else begin
         parity_r <= even_parity(q_next_s);
      end
   end

   assign parity_err = even_parity(q_r) ^ parity_r;
`endif

endmodule

// File: rtl/register.sv
// Byte-enabled storage register with synchronous clear and a one-cycle change flag.
// Defining REGISTER_PARITY_EN adds per-lane even parity and the parity_err output.
module register
   import register_pkg::*;
#(
   parameter int unsigned          WIDTH       = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0]     RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
)
(
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   should_write,
   input  logic [WIDTH/8-1:0]     byte_en,
   input  logic                   clear,
   input  logic [WIDTH-1:0]       in,
`ifdef REGISTER_PARITY_EN
   output logic                   parity_err,
`endif
   output logic [WIDTH-1:0]       out,
   output logic                   changed
);

   localparam int unsigned LANES = lane_count(WIDTH);

   logic [WIDTH-1:0] next_word_s;
   logic [WIDTH-1:0] cur_word_s;
   logic             changed_r;
`ifdef REGISTER_PARITY_EN
   logic [LANES-1:0] lane_err_s;
`endif

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      register_lane u_lane (
         .clock      (clock),
         .reset_n    (reset_n),
         .load       (should_write & byte_en[i]),
         .clr        (clear),
         .d          (in[8*i +: 8]),
         .rst_val    (RESET_VALUE[8*i +: 8]),
         .q_next     (next_word_s[8*i +: 8]),
`ifdef REGISTER_PARITY_EN
         .parity_err (lane_err_s[i]),
`endif
         .q          (cur_word_s[8*i +: 8])
      );
   end

   // Flag an edge that alters the stored word; identical rewrites stay quiet.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         changed_r <= 1'b0;
      end else begin
         changed_r <= (next_word_s != cur_word_s);
      end
   end

   assign out     = cur_word_s;
   assign changed = changed_r;

`ifdef REGISTER_PARITY_EN
   assign parity_err = |lane_err_s;
`endif

endmodule

// File: tb/tb_register.sv
// Directed self-checking bench for the byte-enabled register (default 32-bit build).
module tb_register;

   logic        clock;
   logic        reset_n;
   logic        should_write;
   logic [3:0]  byte_en;
   logic        clear;
   logic [31:0] in;
   logic [31:0] out;
   logic        changed;
`ifdef REGISTER_PARITY_EN
   logic        parity_err;
`endif

   int total_s;
   int bad_s;

   register dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .should_write (should_write),
      .byte_en      (byte_en),
      .clear        (clear),
      .in           (in),
`ifdef REGISTER_PARITY_EN
      .parity_err   (parity_err),
`endif
      .out          (out),
      .changed      (changed)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_s++;
      if (obs !== exp) begin
         bad_s++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      total_s      = 0;
      bad_s        = 0;
      reset_n      = 1'b0;
      should_write = 1'b0;
      byte_en      = 4'h0;
      clear        = 1'b0;
      in           = 32'd0;
      #12;
      check("reset_out", out, 32'h0);
      check("reset_changed", {31'd0, changed}, 32'd0);
      reset_n = 1'b1;

      in = 32'd100;
      tick();
      tick();
      check("idle_out", out, 32'h0);
      check("idle_changed", {31'd0, changed}, 32'd0);

      should_write = 1'b1;
      byte_en      = 4'hF;
      in           = 32'd5;
      tick();
      check("w5_out", out, 32'd5);
      check("w5_changed", {31'd0, changed}, 32'd1);
      tick();
      check("w5_again_out", out, 32'd5);
      check("w5_again_changed", {31'd0, changed}, 32'd0);

      in = 32'd44;
      tick();
      check("w44_out", out, 32'd44);
      should_write = 1'b0;
      in           = 32'd7;
      tick();
      tick();
      check("hold44_out", out, 32'd44);
      check("hold44_changed", {31'd0, changed}, 32'd0);

      in = 32'hXXXX_XXXX;
      tick();
      check("x_hold_out", out, 32'd44);

      should_write = 1'b1;
      in           = 32'h1122_3344;
      tick();
      byte_en = 4'b0101;
      in      = 32'hAABB_CCDD;
      tick();
      check("mask0101_out", out, 32'h11BB_33DD);
      check("mask0101_changed", {31'd0, changed}, 32'd1);

      byte_en = 4'b1000;
      in      = 32'h5566_7788;
      tick();
      check("mask1000_out", out, 32'h55BB_33DD);

      byte_en = 4'b0000;
      in      = 32'hFFFF_FFFF;
      tick();
      check("mask0_out", out, 32'h55BB_33DD);
      check("mask0_changed", {31'd0, changed}, 32'd0);

      byte_en = 4'hF;
      clear   = 1'b1;
      in      = 32'd9;
      tick();
      check("clear_out", out, 32'h0);
      check("clear_changed", {31'd0, changed}, 32'd1);
      tick();
      check("clear_again_changed", {31'd0, changed}, 32'd0);
      clear = 1'b0;

      in = 32'hDEAD_BEEF;
      tick();
      check("wdead_out", out, 32'hDEAD_BEEF);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_out", out, 32'h0);
      check("async_rst_changed", {31'd0, changed}, 32'd0);
      in = 32'h0000_0012;
      tick();
      check("rst_ignores_write", out, 32'h0);
      #2;
      reset_n = 1'b1;
      tick();
      check("first_write_after_rst", out, 32'h0000_0012);
      check("first_write_changed", {31'd0, changed}, 32'd1);

`ifdef REGISTER_PARITY_EN
      in = 32'h0000_00FF;
      tick();
      check("parity_ok", {31'd0, parity_err}, 32'd0);
      should_write = 1'b0;
      force dut.g_lane[0].u_lane.q_r = 8'hFE;
      #1;
      check("parity_flip", {31'd0, parity_err}, 32'd1);
      release dut.g_lane[0].u_lane.q_r;
`endif

      $display("test done: total=%0d bad=%0d", total_s, bad_s);
      $finish;
   end

endmodule
